ft245_tx_burst: RTL and testbench
=================================

FT245_TX_BURST -- requirements
Module: ft245_tx_burst

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FT60x bus width; legal values 16 (FT600) or 32 (FT601).
REQ-002 Parameter DEPTH_LOG2, default 4, TX FIFO depth = 2^DEPTH_LOG2 words.
REQ-003 Parameter MAX_BURST, default 256, maximum words per write burst before a forced gap; legal range 1..65535.
REQ-004 Local BE_WIDTH = DATA_WIDTH/8.
REQ-005 One clock and a synchronous, active-low reset.
REQ-006 clk  in  1  sole clock; FT60x CLK, all logic rising-edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 tx_en  in  1  write strobe for user data.
REQ-009 tx_data  in  DATA_WIDTH  user word.
REQ-010 tx_be  in  BE_WIDTH  byte enables of user word, stored with it.
REQ-011 tx_full  out  1  FIFO holds 2^DEPTH_LOG2 words.
REQ-012 tx_level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-013 tx_overflow  out  1  sticky: a write was dropped while full.
REQ-014 ft_txe_n  in  1  FT60x TXE_N, low = device can accept data.
REQ-015 ft_data_out  out  DATA_WIDTH  word to drive on FT data bus.
REQ-016 ft_be_out  out  BE_WIDTH  byte enables to drive on FT BE bus.
REQ-017 ft_drive  out  1  high = top level enables data/BE output drivers.
REQ-018 ft_wr_n  out  1  FT60x WR_N.
REQ-019 ft_oe_n, ft_rd_n  out  1 each  held high (TX-only block).
REQ-020 busy  out  1  high in BURST or GAP.
REQ-021 words_sent  out  32  count of words accepted by device, wraps at 2^32.

Function
REQ-022 FIFO SHALL be first-word-fall-through; ft_data_out/ft_be_out always show the head entry (don't-care when empty).
REQ-023 A write SHALL occur at a clk edge when tx_en=1 and tx_full=0; tx_en=1 with tx_full=1 SHALL drop the word and set tx_overflow.
REQ-024 tx_full is evaluated before any same-cycle pop: write+pop in one cycle while full SHALL drop the write; when not full both SHALL occur and tx_level SHALL remain unchanged.
REQ-025 States SHALL be IDLE, BURST, GAP, with a registered state and 16-bit burst counter.
REQ-026 IDLE -> BURST at the edge where ft_txe_n=0 and tx_level>0; burst counter cleared.
REQ-027 In BURST, ft_wr_n = 0 whenever FIFO is non-empty, else 1; ft_drive=1 throughout BURST.
REQ-028 A transfer (pop, words_sent+1, burst counter+1) SHALL occur at every edge with state=BURST, ft_wr_n=0 and ft_txe_n=0.
REQ-029 ft_wr_n=0 with ft_txe_n=1 SHALL NOT pop; the word stays at FIFO head for a later burst.
REQ-030 BURST -> GAP at the edge where ft_txe_n=1, or the FIFO becomes empty, or the burst counter reaches MAX_BURST after a transfer.
REQ-031 GAP SHALL last exactly one cycle with ft_wr_n=1, ft_drive=0, then go to IDLE.
REQ-032 In IDLE and GAP: ft_wr_n=1, ft_drive=0, busy as REQ-020.
REQ-033 ft_oe_n and ft_rd_n SHALL be 1 in all states.
REQ-034 tx_be SHALL pass unmodified to ft_be_out with its word; partial words are not merged.

Reset
REQ-035 While rst_n=0 at an edge: FIFO emptied, tx_level=0, tx_full=0, tx_overflow=0, state=IDLE, ft_wr_n=1, ft_drive=0, busy=0, words_sent=0, burst counter=0.
REQ-036 Reset asserted mid-burst SHALL discard all FIFO contents; ft_wr_n=1 at the first edge with rst_n=0.
REQ-037 tx_en while rst_n=0 SHALL be ignored.

Verification
REQ-038 Write 0xBEB0,0xBCB0,0xAAB0 (be=2'b11), ft_txe_n=1 for 1000 cycles -> tx_level=3, ft_wr_n=1 throughout; then ft_txe_n=0 -> three transfers in order on consecutive edges, words_sent=3, GAP, IDLE.
REQ-039 FIFO loaded with 8 words, ft_txe_n raised after 2 transfers -> GAP, IDLE, tx_level=6, head=word 3; ft_txe_n low again -> words 3..8 delivered, none lost or duplicated.
REQ-040 MAX_BURST=4, 10 words queued, ft_txe_n held 0 -> bursts of 4,4,2 each followed by one-cycle ft_wr_n=1 gap; words_sent=10.
REQ-041 DEPTH_LOG2=2: 5 writes with ft_txe_n=1 -> tx_full after 4th, 5th dropped, tx_overflow=1, tx_level=4; write+pop same cycle when level=3 -> level stays 3.
REQ-042 DATA_WIDTH=32, word 0x12345678 be=4'b0111 -> ft_data_out=0x12345678, ft_be_out=4'b0111 on transfer edge.
REQ-043 rst_n=0 for one cycle mid-burst with 5 words queued -> next cycle ft_wr_n=1, tx_level=0, words_sent=0, state IDLE.

Source files
------------

// File: rtl/ft245_tx_burst.sv
// rtl/ft245_tx_burst.sv - FT60x 245-mode transmit path: FWFT FIFO plus burst write sequencer
module ft245_tx_burst #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 4,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tx_en,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic [DATA_WIDTH/8-1:0] tx_be,
  output logic                    tx_full,
  output logic [DEPTH_LOG2:0]     tx_level,
  output logic                    tx_overflow,
  input  logic                    ft_txe_n,
  output logic [DATA_WIDTH-1:0]   ft_data_out,
  output logic [DATA_WIDTH/8-1:0] ft_be_out,
  output logic                    ft_drive,
  output logic                    ft_wr_n,
  output logic                    ft_oe_n,
  output logic                    ft_rd_n,
  output logic                    busy,
  output logic [31:0]             words_sent
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [15:0]         BURST_MAX  = 16'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage; data and byte enables travel together so partial words stay intact
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [BE_WIDTH-1:0]   be_mem   [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  empty;
  logic                  push;
  logic                  pop;

  logic [15:0] burst_cnt;
  logic [15:0] burst_cnt_inc;
  logic        burst_start;
  logic        burst_limit;

  // Full is judged on the pre-pop level, so a write into a full FIFO is dropped
  // even if the same edge frees a slot.
  assign empty   = (level == '0);
  assign tx_full = (level == FULL_LEVEL);
  assign push    = tx_en & ~tx_full;
  assign pop     = (state == BURST) & ~empty & ~ft_txe_n;

  assign burst_cnt_inc = burst_cnt + 16'd1;
  assign burst_limit   = pop & (burst_cnt_inc == BURST_MAX);
  assign burst_start   = (state == IDLE) & (state_next == BURST);

  // Occupancy after this edge, used both for the level register and the empty exit test
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (pop && !push) begin
      level_next = level - 1'b1;
    end
  end

  // Pointer, level and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      if (tx_en && tx_full) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // Storage array write port; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= tx_data;
      be_mem[wr_ptr]   <= tx_be;
    end
  end

  // First-word-fall-through: the head entry is always presented to the bus
  assign ft_data_out = data_mem[rd_ptr];
  assign ft_be_out   = be_mem[rd_ptr];
  assign tx_level    = level;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus bus strobes; a burst ends on device backpressure, an empty
  // FIFO, or reaching the per-burst word limit, and always passes through GAP
  always_comb begin
    state_next = state;
    ft_wr_n    = 1'b1;
    ft_drive   = 1'b0;
    busy       = 1'b0;
    ft_oe_n    = 1'b1;
    ft_rd_n    = 1'b1;
    case (state)
      IDLE: begin
        if (!ft_txe_n && !empty) begin
          state_next = BURST;
        end
      end
      BURST: begin
        busy     = 1'b1;
        ft_drive = 1'b1;
        ft_wr_n  = empty;
        if (ft_txe_n || (level_next == '0) || burst_limit) begin
          state_next = GAP;
        end
      end
      GAP: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-burst word counter, cleared on entry to each new burst
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (burst_start) begin
      burst_cnt <= '0;
    end else if (pop) begin
      burst_cnt <= burst_cnt_inc;
    end
  end

  // Running count of words the device accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_sent <= '0;
    end else if (pop) begin
      words_sent <= words_sent + 32'd1;
    end
  end

endmodule

// File: tb/tb_ft245_tx_burst.sv
// tb/tb_ft245_tx_burst.sv - self-checking bench for ft245_tx_burst
module tb_ft245_tx_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  // instance a: defaults (16-bit, depth 16, max burst 256)
  logic        a_en, a_txe_n, a_full, a_ovf, a_drive, a_wr_n, a_oe_n, a_rd_n, a_busy;
  logic [15:0] a_d, a_dout;
  logic [1:0]  a_be, a_beo;
  logic [4:0]  a_lvl;
  logic [31:0] a_sent;

  // instance b: 16-bit, depth 16, max burst 4
  logic        b_en, b_txe_n, b_full, b_ovf, b_drive, b_wr_n, b_oe_n, b_rd_n, b_busy;
  logic [15:0] b_d, b_dout;
  logic [1:0]  b_be, b_beo;
  logic [4:0]  b_lvl;
  logic [31:0] b_sent;

  // instance c: 32-bit, depth 4, max burst 4
  logic        c_en, c_txe_n, c_full, c_ovf, c_drive, c_wr_n, c_oe_n, c_rd_n, c_busy;
  logic [31:0] c_d, c_dout;
  logic [3:0]  c_be, c_beo;
  logic [2:0]  c_lvl;
  logic [31:0] c_sent;

  ft245_tx_burst u_a (
    .clk(clk), .rst_n(rst_n), .tx_en(a_en), .tx_data(a_d), .tx_be(a_be),
    .tx_full(a_full), .tx_level(a_lvl), .tx_overflow(a_ovf), .ft_txe_n(a_txe_n),
    .ft_data_out(a_dout), .ft_be_out(a_beo), .ft_drive(a_drive), .ft_wr_n(a_wr_n),
    .ft_oe_n(a_oe_n), .ft_rd_n(a_rd_n), .busy(a_busy), .words_sent(a_sent)
  );

  ft245_tx_burst #(.DATA_WIDTH(16), .DEPTH_LOG2(4), .MAX_BURST(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_en(b_en), .tx_data(b_d), .tx_be(b_be),
    .tx_full(b_full), .tx_level(b_lvl), .tx_overflow(b_ovf), .ft_txe_n(b_txe_n),
    .ft_data_out(b_dout), .ft_be_out(b_beo), .ft_drive(b_drive), .ft_wr_n(b_wr_n),
    .ft_oe_n(b_oe_n), .ft_rd_n(b_rd_n), .busy(b_busy), .words_sent(b_sent)
  );

  ft245_tx_burst #(.DATA_WIDTH(32), .DEPTH_LOG2(2), .MAX_BURST(4)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_en(c_en), .tx_data(c_d), .tx_be(c_be),
    .tx_full(c_full), .tx_level(c_lvl), .tx_overflow(c_ovf), .ft_txe_n(c_txe_n),
    .ft_data_out(c_dout), .ft_be_out(c_beo), .ft_drive(c_drive), .ft_wr_n(c_wr_n),
    .ft_oe_n(c_oe_n), .ft_rd_n(c_rd_n), .busy(c_busy), .words_sent(c_sent)
  );

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic [3:0]  be;
    logic        txe_n;
    logic [2:0]  lvl;
    logic        full;
    logic        ovf;
    logic        wr_n;
    logic        busy;
    logic [31:0] head;
    logic [3:0]  hbe;
    logic [31:0] sent;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic a_push(input logic [15:0] d);
    @(negedge clk);
    a_en = 1'b1; a_d = d; a_be = 2'b11;
    @(posedge clk);
    #1 a_en = 1'b0;
  endtask

  task automatic b_push(input logic [15:0] d);
    @(negedge clk);
    b_en = 1'b1; b_d = d; b_be = 2'b11;
    @(posedge clk);
    #1 b_en = 1'b0;
  endtask

  initial begin
    logic [15:0] got [$];
    int          bursts [$];
    int          gaps [$];
    int          run;
    int          grun;
    logic        hold_ok;

    // table for instance c: depth 4 full/overflow, same-cycle write+pop, 32-bit words
    tbl[0]  = '{1'b1, 32'h12345678, 4'b0111, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 4'b0111, 32'd0};
    tbl[1]  = '{1'b1, 32'h11111111, 4'b1111, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 4'b0111, 32'd0};
    tbl[2]  = '{1'b1, 32'h22222222, 4'b0011, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h12345678, 4'b0111, 32'd0};
    tbl[3]  = '{1'b1, 32'h33333333, 4'b1000, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12345678, 4'b0111, 32'd0};
    tbl[4]  = '{1'b1, 32'h44444444, 4'b1111, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h12345678, 4'b0111, 32'd0};
    tbl[5]  = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678, 4'b0111, 32'd0};
    tbl[6]  = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 4'b1111, 32'd1};
    tbl[7]  = '{1'b1, 32'h55555555, 4'b0101, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 4'b0011, 32'd2};
    tbl[8]  = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 4'b0011, 32'd2};
    tbl[9]  = '{1'b0, 32'h00000000, 4'b0000, 1'b1, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 4'b0011, 32'd2};
    tbl[10] = '{1'b1, 32'h66666666, 4'b1111, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 32'h22222222, 4'b0011, 32'd2};
    tbl[11] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 32'h22222222, 4'b0011, 32'd2};
    tbl[12] = '{1'b1, 32'h77777777, 4'b1111, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333, 4'b1000, 32'd3};
    tbl[13] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h55555555, 4'b0101, 32'd4};
    tbl[14] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h66666666, 4'b1111, 32'd5};
    tbl[15] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h00000000, 4'b0000, 32'd6};
    tbl[16] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 32'd6};
    tbl[17] = '{1'b0, 32'h00000000, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 4'b0000, 32'd6};

    rst_n = 1'b0;
    a_en = 1'b0; a_d = '0; a_be = '0; a_txe_n = 1'b1;
    b_en = 1'b0; b_d = '0; b_be = '0; b_txe_n = 1'b1;
    c_en = 1'b0; c_d = '0; c_be = '0; c_txe_n = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_a_lvl",   32'(a_lvl), 32'd0);
    chk("rst_a_full",  32'(a_full), 32'd0);
    chk("rst_a_ovf",   32'(a_ovf), 32'd0);
    chk("rst_a_wr_n",  32'(a_wr_n), 32'd1);
    chk("rst_a_drive", 32'(a_drive), 32'd0);
    chk("rst_a_busy",  32'(a_busy), 32'd0);
    chk("rst_a_sent",  a_sent, 32'd0);
    chk("rst_a_oe_rd", 32'({a_oe_n, a_rd_n}), 32'd3);
    chk("rst_b_wr_n",  32'(b_wr_n), 32'd1);
    chk("rst_c_lvl",   32'(c_lvl), 32'd0);
    rst_n = 1'b1;

    // table-driven run on instance c
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      c_en = tbl[i].en; c_d = tbl[i].d; c_be = tbl[i].be; c_txe_n = tbl[i].txe_n;
      @(negedge clk);
      chk($sformatf("c%0d_lvl", i),   32'(c_lvl), 32'(tbl[i].lvl));
      chk($sformatf("c%0d_full", i),  32'(c_full), 32'(tbl[i].full));
      chk($sformatf("c%0d_ovf", i),   32'(c_ovf), 32'(tbl[i].ovf));
      chk($sformatf("c%0d_wr_n", i),  32'(c_wr_n), 32'(tbl[i].wr_n));
      chk($sformatf("c%0d_busy", i),  32'(c_busy), 32'(tbl[i].busy));
      chk($sformatf("c%0d_drive", i), 32'(c_drive), 32'(tbl[i].busy & ~tbl[i].wr_n));
      chk($sformatf("c%0d_sent", i),  c_sent, tbl[i].sent);
      chk($sformatf("c%0d_oe_rd", i), 32'({c_oe_n, c_rd_n}), 32'd3);
      if (tbl[i].lvl != 3'd0) begin
        chk($sformatf("c%0d_head", i), c_dout, tbl[i].head);
        chk($sformatf("c%0d_hbe", i),  32'(c_beo), 32'(tbl[i].hbe));
      end
    end
    c_en = 1'b0; c_txe_n = 1'b1;

    // three words held back by the device, then released
    a_txe_n = 1'b1;
    a_push(16'hBEB0);
    a_push(16'hBCB0);
    a_push(16'hAAB0);
    hold_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_wr_n !== 1'b1 || a_busy !== 1'b0) hold_ok = 1'b0;
    end
    chk("hold_wr_n_high", 32'(hold_ok), 32'd1);
    chk("hold_lvl", 32'(a_lvl), 32'd3);
    a_txe_n = 1'b0;
    @(negedge clk);
    chk("x1_wr_n", 32'(a_wr_n), 32'd0);
    chk("x1_data", 32'(a_dout), 32'h0000BEB0);
    chk("x1_be",   32'(a_beo), 32'd3);
    @(negedge clk);
    chk("x2_data", 32'(a_dout), 32'h0000BCB0);
    chk("x2_sent", a_sent, 32'd1);
    @(negedge clk);
    chk("x3_data", 32'(a_dout), 32'h0000AAB0);
    chk("x3_wr_n", 32'(a_wr_n), 32'd0);
    @(negedge clk);
    chk("x_gap_wr_n",  32'(a_wr_n), 32'd1);
    chk("x_gap_busy",  32'(a_busy), 32'd1);
    chk("x_gap_drive", 32'(a_drive), 32'd0);
    chk("x_sent",      a_sent, 32'd3);
    chk("x_lvl",       32'(a_lvl), 32'd0);
    @(negedge clk);
    chk("x_idle_busy", 32'(a_busy), 32'd0);

    // backpressure after two transfers, then resume
    a_txe_n = 1'b1;
    for (int i = 0; i < 8; i++) a_push(16'h1001 + 16'(i));
    @(negedge clk);
    a_txe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a_txe_n = 1'b1;
    @(negedge clk);
    chk("bp_gap_busy", 32'(a_busy), 32'd1);
    chk("bp_gap_wr_n", 32'(a_wr_n), 32'd1);
    @(negedge clk);
    chk("bp_idle_busy", 32'(a_busy), 32'd0);
    chk("bp_lvl",  32'(a_lvl), 32'd6);
    chk("bp_head", 32'(a_dout), 32'h00001003);
    chk("bp_sent", a_sent, 32'd5);
    a_txe_n = 1'b0;
    got.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_wr_n == 1'b0 && a_txe_n == 1'b0) got.push_back(a_dout);
    end
    chk("bp_count", 32'(got.size()), 32'd6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("bp_word%0d", i + 3), 32'(got[i]), 32'h00001003 + 32'(i));
    chk("bp_sent_total", a_sent, 32'd11);
    chk("bp_lvl_end", 32'(a_lvl), 32'd0);

    // max-burst splitting on instance b
    b_txe_n = 1'b1;
    for (int i = 0; i < 10; i++) b_push(16'h3001 + 16'(i));
    @(negedge clk);
    b_txe_n = 1'b0;
    got.delete();
    run = 0;
    grun = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_wr_n == 1'b0) begin
        run++;
        got.push_back(b_dout);
      end else if (run > 0) begin
        bursts.push_back(run);
        run = 0;
      end
      if (b_busy == 1'b1 && b_wr_n == 1'b1) begin
        grun++;
      end else if (grun > 0) begin
        gaps.push_back(grun);
        grun = 0;
      end
    end
    chk("mb_bursts", 32'(bursts.size()), 32'd3);
    if (bursts.size() == 3) begin
      chk("mb_b0", 32'(bursts[0]), 32'd4);
      chk("mb_b1", 32'(bursts[1]), 32'd4);
      chk("mb_b2", 32'(bursts[2]), 32'd2);
    end
    chk("mb_gaps", 32'(gaps.size()), 32'd3);
    foreach (gaps[i]) chk($sformatf("mb_gap%0d", i), 32'(gaps[i]), 32'd1);
    chk("mb_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++)
      chk($sformatf("mb_word%0d", i), 32'(got[i]), 32'h00003001 + 32'(i));
    chk("mb_sent", b_sent, 32'd10);

    // reset in the middle of a burst, with a write attempted during reset
    a_txe_n = 1'b1;
    for (int i = 0; i < 5; i++) a_push(16'h2001 + 16'(i));
    @(negedge clk);
    a_txe_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_pre_lvl",  32'(a_lvl), 32'd4);
    chk("mr_pre_sent", a_sent, 32'd12);
    rst_n = 1'b0;
    a_en = 1'b1; a_d = 16'hDEAD; a_be = 2'b11;
    @(negedge clk);
    chk("mr_wr_n",  32'(a_wr_n), 32'd1);
    chk("mr_lvl",   32'(a_lvl), 32'd0);
    chk("mr_sent",  a_sent, 32'd0);
    chk("mr_busy",  32'(a_busy), 32'd0);
    chk("mr_drive", 32'(a_drive), 32'd0);
    chk("mr_full",  32'(a_full), 32'd0);
    chk("mr_ovf",   32'(a_ovf), 32'd0);
    chk("mr_c_ovf", 32'(c_ovf), 32'd0);
    rst_n = 1'b1;
    a_en = 1'b0;
    @(negedge clk);
    chk("mr_after_lvl",  32'(a_lvl), 32'd0);
    chk("mr_after_busy", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
